// File: rtl/app_src_adapter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : app_src_adapter_pkg
//  Description : Shared types for the application source adapter: adapter
//                state encoding, FIFO entry layout and a saturating helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package app_src_adapter_pkg;

  // Width of one application word moving toward the injector
  localparam int unsigned DATA_W = 32;

  // Adapter state: IDLE between applications, APP inside one, DONE after eoa
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    APP  = 2'd1,
    DONE = 2'd2
  } app_src_state_t;

  // One buffered word plus the flag marking the end of its application
  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } app_src_entry_t;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/app_src_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : app_src_fifo
//  Description : Synchronous FIFO of app_src_entry_t words. Registered head,
//                no fall-through; simultaneous push and pop keep the count.
//  Revision    : 1.0 - initial release
// ============================================================================
module app_src_fifo
  import app_src_adapter_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         i_push,
  input  app_src_entry_t               i_entry,
  input  logic                         i_pop,
  output app_src_entry_t               o_head,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH):0]       o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] c_FULL_COUNT = (AW+1)'(DEPTH);

  app_src_entry_t r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [AW:0]    r_count;
  logic           w_wr_en;
  logic           w_rd_en;

  // Writes into a full FIFO and reads from an empty one are dropped here so
  // the pointers can never overrun each other.
  assign w_wr_en = i_push && (r_count != c_FULL_COUNT);
  assign w_rd_en = i_pop  && (r_count != '0);

  // Storage array; contents need no reset because count gates visibility
  always_ff @(posedge clk_i) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= i_entry;
    end
  end

  // Pointers wrap naturally at DEPTH; count tracks occupancy
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr_en, w_rd_en})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == c_FULL_COUNT);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/app_src_adapter.sv
`default_nettype none
// ============================================================================
//  Module      : app_src_adapter
//  Description : Converts a host valid/ready word stream into the credit based
//                rx/credit/data/eoa source interface of the TaskInjector.
//                Buffers words, tracks application boundaries and raises eoa
//                once every queued word has been handed over.
//  Revision    : 1.0 - initial release
// ============================================================================
module app_src_adapter #(
  parameter int unsigned BUFFER_DEPTH  = 8,
  parameter logic [15:0] MAX_APP_WORDS = 16'hFFFF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        s_valid_i,
  output logic        s_ready_o,
  input  logic [31:0] s_data_i,
  input  logic        s_last_i,
  input  logic        eoa_req_i,
  output logic        src_rx_o,
  input  logic        src_credit_i,
  output logic [31:0] src_data_o,
  output logic        src_eoa_o,
  output logic [7:0]  apps_sent_o,
  output logic [15:0] words_in_app_o,
  output logic        app_len_err_o
);

  import app_src_adapter_pkg::*;

  localparam int unsigned AW = $clog2(BUFFER_DEPTH);

  app_src_state_t r_state;
  logic           r_eoa_pending;
  logic           r_eoa;
  logic [7:0]     r_apps_sent;
  logic [15:0]    r_words;
  logic           r_len_err;

  app_src_entry_t w_in;
  app_src_entry_t w_head;
  logic           w_full;
  logic           w_empty;
  logic [AW:0]    w_count;
  logic           w_push;
  logic           w_pop;
  logic           w_done_go;

  // Ready depends only on registered occupancy and state, never on credit
  assign s_ready_o = !w_full && (r_state != DONE);
  assign w_push    = s_valid_i && s_ready_o;
  assign w_pop     = !w_empty && src_credit_i;
  assign w_in      = {s_last_i, s_data_i};

  // Terminal condition: host asked for eoa, no application is open, nothing
  // is left to hand over and nothing is arriving this cycle.
  assign w_done_go = r_eoa_pending && (r_state == IDLE) &&
                     (w_count == '0) && !w_push;

  app_src_fifo #(
    .DEPTH (BUFFER_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_push  (w_push),
    .i_entry (w_in),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Application boundary FSM with the registered eoa indication
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state       <= IDLE;
      r_eoa_pending <= 1'b0;
      r_eoa         <= 1'b0;
    end else begin
      if (eoa_req_i) r_eoa_pending <= 1'b1;
      case (r_state)
        IDLE: begin
          if (w_push && !s_last_i) begin
            r_state <= APP;
          end else if (w_done_go) begin
            r_state <= DONE;
            r_eoa   <= 1'b1;
          end
        end
        APP: begin
          if (w_push && s_last_i) r_state <= IDLE;
        end
        DONE: begin
          r_eoa <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Per-application word count; a last word restarts it for the next app
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_words <= '0;
    end else if (w_push) begin
      r_words <= s_last_i ? 16'd0 : sat_inc16(r_words);
    end
  end

  // Sticky length error; the offending word is still forwarded
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_len_err <= 1'b0;
    end else if (w_push && (r_words == MAX_APP_WORDS)) begin
      r_len_err <= 1'b1;
    end
  end

  // Applications completed toward the injector, wrapping at 8 bits
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_apps_sent <= '0;
    end else if (w_pop && w_head.last) begin
      r_apps_sent <= r_apps_sent + 8'd1;
    end
  end

  assign src_rx_o       = !w_empty;
  assign src_data_o     = w_empty ? 32'd0 : w_head.data;
  assign src_eoa_o      = r_eoa;
  assign apps_sent_o    = r_apps_sent;
  assign words_in_app_o = r_words;
  assign app_len_err_o  = r_len_err;

endmodule
`default_nettype wire

// File: tb/tb_app_src_adapter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_app_src_adapter
//  Description : Directed self-checking bench for app_src_adapter
//                (BUFFER_DEPTH=8, MAX_APP_WORDS=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_app_src_adapter;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        s_valid_i = 1'b0;
  logic        s_ready_o;
  logic [31:0] s_data_i = '0;
  logic        s_last_i = 1'b0;
  logic        eoa_req_i = 1'b0;
  logic        src_rx_o;
  logic        src_credit_i = 1'b0;
  logic [31:0] src_data_o;
  logic        src_eoa_o;
  logic [7:0]  apps_sent_o;
  logic [15:0] words_in_app_o;
  logic        app_len_err_o;

  int checks = 0;
  int errors = 0;

  app_src_adapter #(
    .BUFFER_DEPTH  (8),
    .MAX_APP_WORDS (16'd4)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .s_valid_i      (s_valid_i),
    .s_ready_o      (s_ready_o),
    .s_data_i       (s_data_i),
    .s_last_i       (s_last_i),
    .eoa_req_i      (eoa_req_i),
    .src_rx_o       (src_rx_o),
    .src_credit_i   (src_credit_i),
    .src_data_o     (src_data_o),
    .src_eoa_o      (src_eoa_o),
    .apps_sent_o    (apps_sent_o),
    .words_in_app_o (words_in_app_o),
    .app_len_err_o  (app_len_err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    s_valid_i    = 1'b0;
    s_data_i     = '0;
    s_last_i     = 1'b0;
    eoa_req_i    = 1'b0;
    src_credit_i = 1'b0;
    rst_ni       = 1'b0;
    step();
    step();
    rst_ni = 1'b1;
  endtask

  // Streams n words base+i; last_mask bit i marks word i as last.
  // mode 0: credit always 1, mode 1: credit toggles, mode 2: credit 0 for 10 cycles.
  task automatic run_stream(input int n, input logic [31:0] base, input logic [31:0] last_mask,
                            input int mode, input string tag);
    int h   = 0;
    int k   = 0;
    int cyc = 0;
    while (k < n && cyc < 80) begin
      case (mode)
        1:       src_credit_i = ((cyc % 2) == 0);
        2:       src_credit_i = (cyc >= 10);
        default: src_credit_i = 1'b1;
      endcase
      if (mode == 2 && cyc == 10) begin
        check({tag, " ready_low_when_full"}, 32'(s_ready_o), 32'd0);
        check({tag, " head_held"}, src_data_o, base);
        check({tag, " accepted_before_full"}, 32'(h), 32'd8);
      end
      if (src_rx_o && src_credit_i) begin
        check({tag, " order"}, src_data_o, base + 32'(k));
        k++;
      end
      if (h < n) begin
        s_valid_i = 1'b1;
        s_data_i  = base + 32'(h);
        s_last_i  = last_mask[h];
        if (s_ready_o) h++;
      end else begin
        s_valid_i = 1'b0;
        s_last_i  = 1'b0;
      end
      step();
      cyc++;
    end
    s_valid_i = 1'b0;
    s_last_i  = 1'b0;
    check({tag, " drained_count"}, 32'(k), 32'(n));
  endtask

  initial begin
    // ---------------- reset state ----------------
    step();
    step();
    check("rst rx", 32'(src_rx_o), 32'd0);
    check("rst eoa", 32'(src_eoa_o), 32'd0);
    check("rst apps", 32'(apps_sent_o), 32'd0);
    check("rst words", 32'(words_in_app_o), 32'd0);
    check("rst err", 32'(app_len_err_o), 32'd0);
    rst_ni = 1'b1;
    step();
    check("rst ready", 32'(s_ready_o), 32'd1);

    // ---------------- single 3-word application ----------------
    src_credit_i = 1'b1;
    s_valid_i = 1'b1; s_data_i = 32'hA1; s_last_i = 1'b0;
    step();
    check("t1 rx", 32'(src_rx_o), 32'd1);
    check("t1 d1", src_data_o, 32'hA1);
    check("t1 w1", 32'(words_in_app_o), 32'd1);
    s_data_i = 32'hA2;
    step();
    check("t1 d2", src_data_o, 32'hA2);
    check("t1 w2", 32'(words_in_app_o), 32'd2);
    check("t1 apps0", 32'(apps_sent_o), 32'd0);
    s_data_i = 32'hA3; s_last_i = 1'b1;
    step();
    check("t1 d3", src_data_o, 32'hA3);
    check("t1 w3", 32'(words_in_app_o), 32'd0);
    s_valid_i = 1'b0; s_last_i = 1'b0;
    step();
    check("t1 apps1", 32'(apps_sent_o), 32'd1);
    check("t1 rx_empty", 32'(src_rx_o), 32'd0);

    // ---------------- backpressure: 10 words, depth 8 ----------------
    do_reset();
    run_stream(10, 32'hB00, 32'h200, 2, "t2");
    check("t2 apps", 32'(apps_sent_o), 32'd1);
    check("t2 words", 32'(words_in_app_o), 32'd0);
    check("t2 rx_empty", 32'(src_rx_o), 32'd0);

    // ---------------- eoa requested mid-application ----------------
    do_reset();
    src_credit_i = 1'b1;
    s_valid_i = 1'b1; s_data_i = 32'hC0; s_last_i = 1'b0;
    step();
    s_data_i = 32'hC1;
    step();
    s_data_i = 32'hC2; eoa_req_i = 1'b1;
    step();
    eoa_req_i = 1'b0;
    check("t3 eoa_pending_low", 32'(src_eoa_o), 32'd0);
    check("t3 ready_open", 32'(s_ready_o), 32'd1);
    check("t3 words3", 32'(words_in_app_o), 32'd3);
    s_data_i = 32'hC3; s_last_i = 1'b1;
    step();
    s_valid_i = 1'b0; s_last_i = 1'b0;
    check("t3 d4", src_data_o, 32'hC3);
    check("t3 eoa_before_last", 32'(src_eoa_o), 32'd0);
    step();
    check("t3 rx_after_last", 32'(src_rx_o), 32'd0);
    check("t3 eoa_same_cycle", 32'(src_eoa_o), 32'd0);
    check("t3 apps", 32'(apps_sent_o), 32'd1);
    step();
    check("t3 eoa_rise", 32'(src_eoa_o), 32'd1);
    check("t3 ready_done", 32'(s_ready_o), 32'd0);
    s_valid_i = 1'b1; s_data_i = 32'hDEAD; s_last_i = 1'b0;
    step();
    s_valid_i = 1'b0;
    check("t3 ignored_rx", 32'(src_rx_o), 32'd0);
    check("t3 ignored_words", 32'(words_in_app_o), 32'd0);
    check("t3 eoa_sticky", 32'(src_eoa_o), 32'd1);

    // ---------------- two apps, single-word second, credit toggling ----------------
    do_reset();
    run_stream(3, 32'hD00, 32'h6, 1, "t4");
    check("t4 apps", 32'(apps_sent_o), 32'd2);
    check("t4 words", 32'(words_in_app_o), 32'd0);
    check("t4 ready_idle", 32'(s_ready_o), 32'd1);
    check("t4 eoa", 32'(src_eoa_o), 32'd0);

    // ---------------- length error at MAX_APP_WORDS=4 ----------------
    do_reset();
    src_credit_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      s_valid_i = 1'b1;
      s_data_i  = 32'hE00 + 32'(i);
      s_last_i  = (i == 5);
      step();
      check($sformatf("t5 err_w%0d", i + 1), 32'(app_len_err_o), (i >= 4) ? 32'd1 : 32'd0);
      check($sformatf("t5 fwd_w%0d", i + 1), src_data_o, 32'hE00 + 32'(i));
    end
    s_valid_i = 1'b0; s_last_i = 1'b0;
    step();
    check("t5 apps", 32'(apps_sent_o), 32'd1);
    check("t5 err_sticky", 32'(app_len_err_o), 32'd1);

    // ---------------- async reset with words buffered ----------------
    do_reset();
    src_credit_i = 1'b1;
    s_valid_i = 1'b1; s_data_i = 32'h600; s_last_i = 1'b1;
    step();
    s_valid_i = 1'b0; s_last_i = 1'b0;
    step();
    check("t6 apps_pre", 32'(apps_sent_o), 32'd1);
    src_credit_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_valid_i = 1'b1;
      s_data_i  = 32'hF00 + 32'(i);
      step();
    end
    s_valid_i = 1'b0;
    check("t6 rx_pre", 32'(src_rx_o), 32'd1);
    check("t6 words_pre", 32'(words_in_app_o), 32'd5);
    check("t6 err_pre", 32'(app_len_err_o), 32'd1);
    #2 rst_ni = 1'b0;
    #1;
    check("t6 rx_async", 32'(src_rx_o), 32'd0);
    check("t6 data_async", src_data_o, 32'd0);
    check("t6 eoa_async", 32'(src_eoa_o), 32'd0);
    check("t6 apps_async", 32'(apps_sent_o), 32'd0);
    check("t6 words_async", 32'(words_in_app_o), 32'd0);
    check("t6 err_async", 32'(app_len_err_o), 32'd0);
    step();
    rst_ni = 1'b1;
    src_credit_i = 1'b1;
    s_valid_i = 1'b1; s_data_i = 32'h700; s_last_i = 1'b1;
    step();
    s_valid_i = 1'b0; s_last_i = 1'b0;
    check("t6 new_data", src_data_o, 32'h700);
    check("t6 new_words", 32'(words_in_app_o), 32'd0);
    check("t6 new_apps0", 32'(apps_sent_o), 32'd0);
    step();
    check("t6 new_apps1", 32'(apps_sent_o), 32'd1);
    check("t6 new_rx", 32'(src_rx_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/app_src_adapter.md
Name: app_src_adapter

Overview:
- Upstream feeder for the application TaskInjector. Converts a host-side valid/ready word stream into the credit-based rx/credit/data/eoa source interface the injector consumes.
- Buffers words in a FIFO and tracks application boundaries.
- Generates the end-of-applications (eoa) indication once every queued application word has been handed to the injector.
- Sits between the testbench/host loader and the many-core top's app_src_* ports.

Parameters:
BUFFER_DEPTH, 8, FIFO depth in 32-bit words; power of two, >= 2.
MAX_APP_WORDS, 16'hFFFF, words allowed per application before the length error flag is raised.

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
s_valid_i  input  1  host word valid
s_ready_o  output  1  adapter can accept a host word this cycle
s_data_i  input  32  host word
s_last_i  input  1  qualifies s_data_i as the final word of the current application
eoa_req_i  input  1  host pulse/level: no further applications follow
src_rx_o  output  1  word valid toward injector (app_src_rx_i)
src_credit_i  input  1  injector can accept a word (app_src_credit_o)
src_data_o  output  32  word toward injector (app_src_data_i)
src_eoa_o  output  1  end of applications toward injector (app_src_eoa_i)
apps_sent_o  output  8  count of applications fully handed to injector; wraps at 255->0
words_in_app_o  output  16  host words accepted in the current application; saturates at 16'hFFFF
app_len_err_o  output  1  sticky: an application exceeded MAX_APP_WORDS

Behaviour:
- Reset (async, rst_ni=0): FIFO empty, state IDLE, eoa_pending=0.
  - All outputs 0 except s_ready_o=1 once reset is released.
  - Reset mid-operation discards buffered words and clears all counters and flags.
- Host handshake:
  - A word is accepted on a rising edge with s_valid_i && s_ready_o.
  - s_ready_o = (count != BUFFER_DEPTH) && state != DONE. Driven from registered state only; no combinational path from src_credit_i.
- FIFO entries are 33 bits {last, data}.
- Injector handshake:
  - src_rx_o = !empty; src_data_o = head data.
  - A word transfers on a rising edge with src_rx_o && src_credit_i.
  - src_data_o is held stable while src_rx_o=1 and src_credit_i=0.
- Latency: a word accepted at edge N is visible on src_rx_o/src_data_o after edge N (next cycle) when the FIFO was empty. No fall-through.
- Simultaneous push and pop: count unchanged; both pointers advance.
  - At full, push is blocked by s_ready_o=0 even if a pop occurs in the same cycle.
- Pointers: log2(BUFFER_DEPTH) bits, natural wrap; count is log2(BUFFER_DEPTH)+1 bits.
- States:
  - IDLE: no application in progress.
    - Accepted word with s_last_i=0 -> APP.
    - Accepted word with s_last_i=1 (single-word app) stays in IDLE.
  - APP: accepted word with s_last_i=1 -> IDLE.
  - DONE: terminal until reset. s_ready_o=0; host words are ignored.
- words_in_app_o:
  - Increments on each accepted word, saturating at 16'hFFFF.
  - Loads 0 on the edge accepting a last word (next app starts at 0).
- app_len_err_o: set when a word is accepted while words_in_app_o == MAX_APP_WORDS; sticky until reset. The word is still forwarded.
- apps_sent_o increments when a FIFO entry with last=1 transfers to the injector.
- eoa handling:
  - eoa_req_i=1 in any state sets eoa_pending (sticky).
  - Transition to DONE when eoa_pending && state==IDLE && FIFO empty && no push this cycle.
  - src_eoa_o=1 registered in DONE; it therefore rises the cycle after the last word transfers, never concurrently with src_rx_o=1.
- eoa_req_i asserted in the same cycle as an accepted word: the word is accepted and eoa stays pending.

Decomposition:
- Shared package (PhiversPkg):
  - state enum app_src_state_t {IDLE, APP, DONE}
  - typedef app_src_entry_t: packed struct {logic last; logic [31:0] data}
- One sub-module: app_src_fifo. Parameterised synchronous FIFO carrying app_src_entry_t; push/pop/full/empty/count; async active-low reset.
- The FSM and counters live in app_src_adapter.

Test Plan:
- Single app of 3 words (0xA1,0xA2,0xA3 last), src_credit_i=1 → src_data_o shows A1,A2,A3 on consecutive cycles starting the cycle after first accept; apps_sent_o 0→1 on A3 transfer; words_in_app_o 1,2,0.
- src_credit_i=0 with host streaming 10 words, BUFFER_DEPTH=8 → s_ready_o falls after 8 accepts; src_data_o held at word 0; releasing credit drains all 10 in order with no loss or duplication.
- eoa_req_i pulsed mid-app (after word 2 of 4) → src_eoa_o stays 0 until the 4th word transfers, rises exactly one cycle later; s_ready_o=0 thereafter.
- Two apps back-to-back, second single-word (last on first word), credit toggling 1/0 every cycle → apps_sent_o ends at 2; state returns to IDLE; order preserved.
- MAX_APP_WORDS=4, app of 6 words → app_len_err_o rises on acceptance of word 5, stays 1; all 6 words forwarded.
- rst_ni asserted with 5 words buffered → src_rx_o, src_eoa_o, counters go to 0 immediately (async); after release, new app data flows with fresh counts.
